sprite_compositor_ctrl: RTL and testbench
=========================================

SPRITE_COMPOSITOR_CTRL -- requirements
Module: sprite_compositor_ctrl

Interface
REQ-001 Parameters: H_ACTIVE 640, frame width in pixels; V_ACTIVE 480, frame height in lines; SPR_W 32, sprite width; SPR_H 32, sprite height; TRANSP_KEY 8'hEE, RGB332 transparent color (pink 255,102,204).
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- pix_req  in  1  pixel request strobe from video timing.
- pix_x  in  10  column of the request.
- pix_y  in  10  line of the request.
- frame_start  in  1  one-cycle pulse at vertical blank.
- bg_addr  out  19  background ROM address.
- bg_data  in  8  background ROM data.
- spr_addr  out  10  sprite ROM address.
- spr_data  in  8  sprite ROM data.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write accepted.
- cfg_x  in  10  sprite top-left column.
- cfg_y  in  10  sprite top-left line.
- cfg_en  in  1  sprite visible.
- pix_out  out  8  composited RGB332 pixel.
- pix_out_valid  out  1  pix_out qualifier.
REQ-003 Both ROMs are synchronous with 1-cycle read latency: data for an address presented in cycle N appears in cycle N+1.

Function
REQ-004 Stage 0 (the cycle in which pix_req=1) registers bg_addr = pix_y*H_ACTIVE + pix_x, evaluated at 19-bit width.
REQ-005 Stage 0 registers hit = act_en AND act_x <= pix_x < act_x+SPR_W AND act_y <= pix_y < act_y+SPR_H.
- All comparisons use 11-bit arithmetic.
- A sprite extending past the frame edge is clipped and never wraps.
REQ-006 On hit, stage 0 registers spr_addr = (pix_y-act_y)*SPR_W + (pix_x-act_x).
- On no hit, spr_addr is held at 0.
REQ-007 Stage 1 selects pix_out = spr_data when hit=1 and spr_data != TRANSP_KEY; otherwise pix_out = bg_data.
REQ-008 Latency: pix_out_valid asserts exactly 2 cycles after pix_req, with the pix_out for that request.
REQ-009 Throughput: one request per cycle, no bubbles. Back-to-back requests produce back-to-back valid outputs in order.
REQ-010 Out-of-frame requests (pix_x >= H_ACTIVE or pix_y >= V_ACTIVE):
- bg_addr and spr_addr are held at 0.
- The output is pix_out=8'h00 with pix_out_valid=1 at the normal latency.
REQ-011 When pix_req=0, pix_out_valid=0 two cycles later and pix_out holds its last value.
REQ-012 The configuration FSM has two states, IDLE and PENDING.
- cfg_ready = 1 in IDLE and 0 in PENDING.
REQ-013 In IDLE, cfg_valid=1 latches cfg_x/cfg_y/cfg_en into the shadow registers and moves to PENDING.
REQ-014 In PENDING, frame_start=1 copies shadow to the active registers (act_x, act_y, act_en) and returns to IDLE.
- The new values govern every pix_req from the next cycle onward.
REQ-015 Simultaneous cfg accept and frame_start while in IDLE:
- The write goes to shadow and the FSM enters PENDING.
- Active registers are unchanged until the next frame_start.
REQ-016 frame_start in IDLE has no effect.
REQ-017 Active registers never change mid-frame, i.e. outside a frame_start cycle.

Reset
REQ-018 While rst=1:
- act_x=0, act_y=0, act_en=0.
- Shadow registers are 0.
- FSM=IDLE; cfg_ready=0.
- bg_addr=0, spr_addr=0, pix_out=0, pix_out_valid=0.
- All pipeline valid and hit flags are cleared.
REQ-019 cfg_ready=1 in the first cycle after rst deasserts.
REQ-020 rst asserted mid-operation:
- In-flight requests are discarded; no pix_out_valid is produced for them.
- A pending configuration is lost.

Verification
REQ-021 Reset, then act_en=0; pix_req at (100,50) with bg_data=8'h1C -> bg_addr=32100 one cycle later; pix_out=8'h1C with pix_out_valid two cycles after the request.
REQ-022 cfg write (x=100, y=50, en=1) followed by frame_start; pix_req at (105,52) -> spr_addr=69.
- spr_data=8'hE0 -> pix_out=8'hE0.
- spr_data=8'hEE -> pix_out equals bg_data.
REQ-023 Sprite at x=620 (clipped at the right edge): pix_req at (639,0) is a hit with spr_addr=19.
- pix_req at (0,1) is not a hit, so there is no wrap.
REQ-024 cfg write and frame_start in the same cycle -> cfg_ready=0 afterwards; act_en unchanged; the second frame_start applies the write and cfg_ready returns to 1.
REQ-025 640 consecutive pix_req cycles -> 640 consecutive pix_out_valid cycles, in order, starting 2 cycles after the first request.
- rst asserted mid-burst -> pix_out_valid drops the cycle after rst.
REQ-026 pix_req at (640,10) -> pix_out=8'h00 with valid at latency 2; bg_addr=0.

Source files
------------

// File: rtl/sprite_compositor_ctrl.sv
// Sprite compositor: overlays one SPR_W x SPR_H sprite on a background frame.
// Two-stage pixel pipeline around 1-cycle synchronous ROMs, plus a
// shadow/active configuration handshake that only takes effect at frame_start.
module sprite_compositor_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter logic [7:0]  TRANSP_KEY = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_req,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        frame_start,
  output logic [18:0] bg_addr,
  input  logic [7:0]  bg_data,
  output logic [9:0]  spr_addr,
  input  logic [7:0]  spr_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [9:0]  cfg_x,
  input  logic [9:0]  cfg_y,
  input  logic        cfg_en,
  output logic [7:0]  pix_out,
  output logic        pix_out_valid
);

  typedef enum logic {StIdle, StPending} cfg_state_e;

  cfg_state_e  state_q, state_d;
  logic [9:0]  shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic        shd_en_q, shd_en_d;
  logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
  logic        act_en_q, act_en_d;

  logic [18:0] bg_addr_q, bg_addr_d;
  logic [9:0]  spr_addr_q, spr_addr_d;
  logic        v1_q, v1_d, hit1_q, hit1_d, oof1_q, oof1_d;
  logic        v2_q, v2_d, hit2_q, hit2_d, oof2_q, oof2_d;
  logic [7:0]  pix_hold_q, pix_hold_d;

  logic [10:0] px, py, ax, ay, dx, dy;
  logic        in_frame, hit;
  logic [18:0] bg_lin;
  logic [9:0]  spr_lin;
  logic [7:0]  sel_pix;

  // Config FSM: accept into shadow in idle, publish to active on frame_start.
  always_comb begin
    state_d  = state_q;
    shd_x_d  = shd_x_q;
    shd_y_d  = shd_y_q;
    shd_en_d = shd_en_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    act_en_d = act_en_q;
    unique case (state_q)
      StIdle: begin
        // frame_start is ignored here, even when it coincides with a write
        if (cfg_valid) begin
          shd_x_d  = cfg_x;
          shd_y_d  = cfg_y;
          shd_en_d = cfg_en;
          state_d  = StPending;
        end
      end
      StPending: begin
        if (frame_start) begin
          act_x_d  = shd_x_q;
          act_y_d  = shd_y_q;
          act_en_d = shd_en_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 0 decode: frame bounds, sprite hit (11-bit so the sprite clips), addresses.
  always_comb begin
    px       = {1'b0, pix_x};
    py       = {1'b0, pix_y};
    ax       = {1'b0, act_x_q};
    ay       = {1'b0, act_y_q};
    dx       = px - ax;
    dy       = py - ay;
    in_frame = (px < 11'(H_ACTIVE)) && (py < 11'(V_ACTIVE));
    hit      = act_en_q && in_frame &&
               (px >= ax) && (px < ax + 11'(SPR_W)) &&
               (py >= ay) && (py < ay + 11'(SPR_H));
    bg_lin   = 19'(pix_y) * 19'(H_ACTIVE) + 19'(pix_x);
    spr_lin  = 10'(dy * 11'(SPR_W) + dx);

    bg_addr_d  = bg_addr_q;
    spr_addr_d = spr_addr_q;
    if (pix_req) begin
      bg_addr_d  = in_frame ? bg_lin : 19'd0;
      spr_addr_d = hit ? spr_lin : 10'd0;
    end
    v1_d   = pix_req;
    hit1_d = pix_req & hit;
    oof1_d = pix_req & ~in_frame;
    v2_d   = v1_q;
    hit2_d = hit1_q;
    oof2_d = oof1_q;
  end

  // Stage 1 select: ROM data is valid now; hold the last pixel when idle.
  always_comb begin
    sel_pix = bg_data;
    if (oof2_q) begin
      sel_pix = 8'h00;
    end else if (hit2_q && (spr_data != TRANSP_KEY)) begin
      sel_pix = spr_data;
    end
    pix_hold_d = v2_q ? sel_pix : pix_hold_q;
  end

  // Outputs are forced to their reset values for the whole time rst is high.
  always_comb begin
    bg_addr       = rst ? 19'd0 : bg_addr_q;
    spr_addr      = rst ? 10'd0 : spr_addr_q;
    pix_out       = rst ? 8'h00 : (v2_q ? sel_pix : pix_hold_q);
    pix_out_valid = v2_q & ~rst;
    cfg_ready     = (state_q == StIdle) & ~rst;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shd_x_q    <= '0;
      shd_y_q    <= '0;
      shd_en_q   <= 1'b0;
      act_x_q    <= '0;
      act_y_q    <= '0;
      act_en_q   <= 1'b0;
      bg_addr_q  <= '0;
      spr_addr_q <= '0;
      v1_q       <= 1'b0;
      hit1_q     <= 1'b0;
      oof1_q     <= 1'b0;
      v2_q       <= 1'b0;
      hit2_q     <= 1'b0;
      oof2_q     <= 1'b0;
      pix_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      shd_x_q    <= shd_x_d;
      shd_y_q    <= shd_y_d;
      shd_en_q   <= shd_en_d;
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      act_en_q   <= act_en_d;
      bg_addr_q  <= bg_addr_d;
      spr_addr_q <= spr_addr_d;
      v1_q       <= v1_d;
      hit1_q     <= hit1_d;
      oof1_q     <= oof1_d;
      v2_q       <= v2_d;
      hit2_q     <= hit2_d;
      oof2_q     <= oof2_d;
      pix_hold_q <= pix_hold_d;
    end
  end

endmodule

// File: tb/tb_sprite_compositor_ctrl.sv
// Directed bench for sprite_compositor_ctrl: vector table plus multi-cycle sequences.
module tb_sprite_compositor_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_req;
  logic [9:0]  pix_x, pix_y;
  logic        frame_start;
  logic [18:0] bg_addr;
  logic [7:0]  bg_data;
  logic [9:0]  spr_addr;
  logic [7:0]  spr_data;
  logic        cfg_valid, cfg_ready;
  logic [9:0]  cfg_x, cfg_y;
  logic        cfg_en;
  logic [7:0]  pix_out;
  logic        pix_out_valid;

  logic [7:0]  spr69;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sprite_compositor_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pix_req      (pix_req),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .frame_start  (frame_start),
    .bg_addr      (bg_addr),
    .bg_data      (bg_data),
    .spr_addr     (spr_addr),
    .spr_data     (spr_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_x        (cfg_x),
    .cfg_y        (cfg_y),
    .cfg_en       (cfg_en),
    .pix_out      (pix_out),
    .pix_out_valid(pix_out_valid)
  );

  function automatic logic [7:0] bg_fn(input logic [18:0] a);
    if (a == 19'd32100) return 8'h1C;
    return a[7:0] ^ {a[12:8], a[18:16]};
  endfunction

  function automatic logic [7:0] spr_fn(input logic [9:0] a);
    if (a == 10'd69) return spr69;
    if (a[3:0] == 4'h5) return 8'hEE;
    return a[7:0] ^ 8'hA5;
  endfunction

  // Synchronous ROM models, one cycle of read latency.
  always @(posedge clk) begin
    bg_data  <= bg_fn(bg_addr);
    spr_data <= spr_fn(spr_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic one_req(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic [18:0] eb, input logic [9:0] es, input logic [7:0] ep);
    @(posedge clk); #1;
    pix_req = 1'b1; pix_x = x; pix_y = y;
    @(posedge clk); #1;
    pix_req = 1'b0;
    @(negedge clk);
    chk({name, "/bg_addr"}, 32'(bg_addr), 32'(eb));
    chk({name, "/spr_addr"}, 32'(spr_addr), 32'(es));
    chk({name, "/valid_early"}, 32'(pix_out_valid), 32'd0);
    @(negedge clk);
    chk({name, "/valid"}, 32'(pix_out_valid), 32'd1);
    chk({name, "/pix"}, 32'(pix_out), 32'(ep));
    @(negedge clk);
    chk({name, "/valid_off"}, 32'(pix_out_valid), 32'd0);
    chk({name, "/pix_hold"}, 32'(pix_out), 32'(ep));
  endtask

  task automatic cfg_write(input string name, input logic [9:0] x, input logic [9:0] y,
                           input logic en, input logic fs);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_x = x; cfg_y = y; cfg_en = en; frame_start = fs;
    @(negedge clk);
    chk({name, "/ready_idle"}, 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    chk({name, "/ready_pend"}, 32'(cfg_ready), 32'd0);
  endtask

  task automatic frame_pulse(input string name);
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk({name, "/ready"}, 32'(cfg_ready), 32'd1);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hit;
    logic        oof;
    logic [18:0] bg;
    logic [9:0]  spr;
  } vec_t;

  vec_t        vecs[10];
  logic [7:0]  ep;

  initial begin
    // Sprite at (100,50), 32x32, enabled
    vecs[0] = '{10'd100, 10'd50,  1'b1, 1'b0, 19'd32100,  10'd0};
    vecs[1] = '{10'd131, 10'd81,  1'b1, 1'b0, 19'd51971,  10'd1023};
    vecs[2] = '{10'd132, 10'd50,  1'b0, 1'b0, 19'd32132,  10'd0};
    vecs[3] = '{10'd99,  10'd60,  1'b0, 1'b0, 19'd38499,  10'd0};
    vecs[4] = '{10'd110, 10'd82,  1'b0, 1'b0, 19'd52590,  10'd0};
    vecs[5] = '{10'd105, 10'd52,  1'b1, 1'b0, 19'd33385,  10'd69};
    vecs[6] = '{10'd639, 10'd479, 1'b0, 1'b0, 19'd307199, 10'd0};
    vecs[7] = '{10'd640, 10'd10,  1'b0, 1'b1, 19'd0,      10'd0};
    vecs[8] = '{10'd5,   10'd480, 1'b0, 1'b1, 19'd0,      10'd0};
    vecs[9] = '{10'd120, 10'd70,  1'b1, 1'b0, 19'd44920,  10'd660};

    rst = 1'b1; pix_req = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0;
    cfg_valid = 1'b0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0; spr69 = 8'hE0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst/valid", 32'(pix_out_valid), 32'd0);
    chk("rst/pix", 32'(pix_out), 32'd0);
    chk("rst/bg_addr", 32'(bg_addr), 32'd0);
    chk("rst/spr_addr", 32'(spr_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst/ready_after", 32'(cfg_ready), 32'd1);

    // Sprite disabled: background only
    one_req("bg_only", 10'd100, 10'd50, 19'd32100, 10'd0, 8'h1C);

    // Write is only shadowed until frame_start
    cfg_write("cfg1", 10'd100, 10'd50, 1'b1, 1'b0);
    one_req("pending", 10'd105, 10'd52, 19'd33385, 10'd0, bg_fn(19'd33385));
    frame_pulse("fs1");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].oof) ep = 8'h00;
      else if (vecs[i].hit && spr_fn(vecs[i].spr) != 8'hEE) ep = spr_fn(vecs[i].spr);
      else ep = bg_fn(vecs[i].bg);
      one_req($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bg, vecs[i].spr, ep);
    end

    // Transparent key shows the background
    spr69 = 8'hEE;
    one_req("transp", 10'd105, 10'd52, 19'd33385, 10'd69, bg_fn(19'd33385));
    spr69 = 8'hE0;

    // Write coinciding with frame_start in idle: only shadowed
    cfg_write("cfg_same", 10'd620, 10'd0, 1'b1, 1'b1);
    one_req("same_old", 10'd105, 10'd52, 19'd33385, 10'd69, 8'hE0);
    frame_pulse("fs2");
    one_req("clip_r", 10'd639, 10'd0, 19'd639, 10'd19, spr_fn(10'd19));
    one_req("no_wrap", 10'd0, 10'd1, 19'd640, 10'd0, bg_fn(19'd640));

    // Full-line burst on row 100 (no sprite there)
    for (int c = 0; c <= 642; c++) begin
      @(posedge clk); #1;
      pix_req = (c < 640);
      pix_x   = 10'(c);
      pix_y   = 10'd100;
      @(negedge clk);
      if (c >= 2 && c - 2 < 640) begin
        chk($sformatf("burst%0d/valid", c - 2), 32'(pix_out_valid), 32'd1);
        chk($sformatf("burst%0d/pix", c - 2), 32'(pix_out),
            32'(bg_fn(19'(64000 + c - 2))));
      end else if (c >= 2) begin
        chk("burst/valid_end", 32'(pix_out_valid), 32'd0);
      end
    end

    // Reset mid-burst with a pending configuration
    cfg_write("cfg_lost", 10'd5, 10'd5, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      pix_req = (c < 12);
      pix_x   = 10'(c);
      pix_y   = 10'd200;
      rst     = (c == 8 || c == 9);
      @(negedge clk);
      if (c >= 9 && c <= 11) chk($sformatf("midrst%0d/valid", c), 32'(pix_out_valid), 32'd0);
      if (c == 10) chk("midrst/cfg_ready", 32'(cfg_ready), 32'd1);
      if (c == 12) begin
        chk("midrst/valid_resume", 32'(pix_out_valid), 32'd1);
        chk("midrst/pix_resume", 32'(pix_out), 32'(bg_fn(19'd128010)));
      end
    end
    frame_pulse("fs3");
    one_req("cfg_dropped", 10'd7, 10'd7, 19'd4487, 10'd0, bg_fn(19'd4487));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
